// File: rtl/accelerator_activation_pkg.sv
// ============================================================================
// Module      : accelerator_activation_pkg
// Description : Shared constants for the activation stages (hard-swish).
// Revision    : 1.1 - add reciprocal-of-six constants
// ============================================================================
`default_nettype none

package accelerator_activation_pkg;

    localparam int SWISH_CONST_THREE = 3;
    localparam int SWISH_CONST_SIX   = 6;

    // 1/6 as a 16-bit fixed-point multiplier: round(2^16 / 6)
    localparam int RECIP_SIX   = 10923;
    localparam int RECIP_SHIFT = 16;
    localparam int RECIP_W     = 16;

    function automatic int fx_scale(input int value, input int frac_bits);
        return value << frac_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hswish_lane.sv
// ============================================================================
// Module      : hswish_lane
// Description : Three-stage single-element hard-swish datapath with a global
//               advance enable. Optional ReLU6 bypass under ACT_RELU6_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hswish_lane
    import accelerator_activation_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int FRAC_BITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_adv,
    input  logic signed [DATA_W-1:0] i_x,
`ifdef ACT_RELU6_EN
    input  logic                     i_relu6_sel,
`endif
    output logic signed [DATA_W-1:0] o_y
);

    localparam int T_W = DATA_W + 2;
    localparam int P_W = 2 * DATA_W + 2;
    localparam int Q_W = P_W + RECIP_W;
    localparam int SH  = RECIP_SHIFT + FRAC_BITS;

    localparam logic signed [T_W-1:0]    c_three  = T_W'(fx_scale(SWISH_CONST_THREE, FRAC_BITS));
    localparam logic signed [T_W-1:0]    c_six    = T_W'(fx_scale(SWISH_CONST_SIX, FRAC_BITS));
    localparam logic signed [Q_W-1:0]    c_recip  = Q_W'(RECIP_SIX);
    localparam logic signed [Q_W-1:0]    c_half   = Q_W'(64'sd1 <<< (SH - 1));
    localparam logic signed [Q_W-1:0]    c_ymax   = Q_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [Q_W-1:0]    c_ymin   = Q_W'(-(64'sd1 <<< (DATA_W - 1)));
    localparam logic signed [DATA_W-1:0] c_ymax_d = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] c_ymin_d = {1'b1, {(DATA_W-1){1'b0}}};

    // ---------------- S1: gate t = clamp(x + 3, 0, 6) ----------------
    logic signed [T_W-1:0]    w_x_ext;
    logic signed [T_W-1:0]    w_sum;
    logic signed [T_W-1:0]    w_t;
    logic signed [DATA_W-1:0] r_x1;
    logic signed [T_W-1:0]    r_t1;

    assign w_x_ext = {{2{i_x[DATA_W-1]}}, i_x};
    assign w_sum   = w_x_ext + c_three;

    always_comb begin
        if (w_sum[T_W-1]) begin
            w_t = '0;
        end else if (w_sum > c_six) begin
            w_t = c_six;
        end else begin
            w_t = w_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x1 <= '0;
            r_t1 <= '0;
        end else if (i_adv) begin
            r_x1 <= i_x;
            r_t1 <= w_t;
        end
    end

    // ---------------- S2: product p = x * t ----------------
    logic signed [P_W-1:0] w_x1_ext;
    logic signed [P_W-1:0] w_t1_ext;
    logic signed [P_W-1:0] w_p;
    logic signed [P_W-1:0] r_p2;

    assign w_x1_ext = {{(P_W-DATA_W){r_x1[DATA_W-1]}}, r_x1};
    assign w_t1_ext = {{(P_W-T_W){r_t1[T_W-1]}}, r_t1};
    assign w_p      = w_x1_ext * w_t1_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p2 <= '0;
        end else if (i_adv) begin
            r_p2 <= w_p;
        end
    end

    // ---------------- S3: divide by six, round half-up, saturate ----------------
    logic signed [Q_W-1:0]    w_p2_ext;
    logic signed [Q_W-1:0]    w_q;
    logic signed [Q_W-1:0]    w_round;
    logic signed [Q_W-1:0]    w_shift;
    logic signed [DATA_W-1:0] w_hswish;
    logic signed [DATA_W-1:0] w_y;
    logic signed [DATA_W-1:0] r_y3;

    assign w_p2_ext = {{(Q_W-P_W){r_p2[P_W-1]}}, r_p2};
    assign w_q      = w_p2_ext * c_recip;
    assign w_round  = w_q + c_half;
    assign w_shift  = w_round >>> SH;

    always_comb begin
        if (w_shift > c_ymax) begin
            w_hswish = c_ymax_d;
        end else if (w_shift < c_ymin) begin
            w_hswish = c_ymin_d;
        end else begin
            w_hswish = w_shift[DATA_W-1:0];
        end
    end

`ifdef ACT_RELU6_EN
    // The selector and raw x ride alongside the product so the choice is per beat.
    logic                     r_sel1;
    logic                     r_sel2;
    logic signed [DATA_W-1:0] r_x2;
    logic signed [T_W-1:0]    w_x2_ext;
    logic signed [DATA_W-1:0] w_relu6;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel1 <= 1'b0;
            r_sel2 <= 1'b0;
            r_x2   <= '0;
        end else if (i_adv) begin
            r_sel1 <= i_relu6_sel;
            r_sel2 <= r_sel1;
            r_x2   <= r_x1;
        end
    end

    assign w_x2_ext = {{2{r_x2[DATA_W-1]}}, r_x2};

    always_comb begin
        if (r_x2[DATA_W-1]) begin
            w_relu6 = '0;
        end else if (w_x2_ext > c_six) begin
            w_relu6 = c_six[DATA_W-1:0];
        end else begin
            w_relu6 = r_x2;
        end
    end

    assign w_y = r_sel2 ? w_relu6 : w_hswish;
`else
    assign w_y = w_hswish;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y3 <= '0;
        end else if (i_adv) begin
            r_y3 <= w_y;
        end
    end

    assign o_y = r_y3;

endmodule

`default_nettype wire

// File: rtl/hswish_unit.sv
// ============================================================================
// Module      : hswish_unit
// Description : Multi-lane pipelined hard-swish stage with valid/ready flow
//               control. Define ACT_RELU6_EN to add the per-beat ReLU6 select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hswish_unit
    import accelerator_activation_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int DATA_W    = 8,
    parameter int FRAC_BITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data,
`ifdef ACT_RELU6_EN
    input  logic                      relu6_sel,
`endif
    output logic                      out_last
);

    localparam int STAGES = 3;

    logic              w_adv;
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_last;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign w_adv    = !r_valid[STAGES-1] || out_ready;
    assign in_ready = w_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_last  <= '0;
        end else if (w_adv) begin
            r_valid <= {r_valid[STAGES-2:0], in_valid};
            r_last  <= {r_last[STAGES-2:0], in_valid & in_last};
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign out_last  = r_last[STAGES-1];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        hswish_lane #(
            .DATA_W    (DATA_W),
            .FRAC_BITS (FRAC_BITS)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_adv       (w_adv),
            .i_x         (in_data[g*DATA_W +: DATA_W]),
`ifdef ACT_RELU6_EN
            .i_relu6_sel (relu6_sel),
`endif
            .o_y         (out_data[g*DATA_W +: DATA_W])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_hswish_unit.sv
// ============================================================================
// Module      : tb_hswish_unit
// Description : Self-checking bench for hswish_unit with a scoreboard and an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hswish_unit;

    localparam int LANES     = 4;
    localparam int DATA_W    = 8;
    localparam int FRAC_BITS = 4;
    localparam int W         = LANES * DATA_W;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;
    logic         relu6_sel;

    hswish_unit #(
        .LANES     (LANES),
        .DATA_W    (DATA_W),
        .FRAC_BITS (FRAC_BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef ACT_RELU6_EN
        .relu6_sel (relu6_sel),
`endif
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        logic         sel;
        int           cyc;
    } beat_t;

    beat_t        sb[$];
    int           n_checks  = 0;
    int           n_errors  = 0;
    int           cyc       = 0;
    bit           took      = 1'b0;
    bit           full_rate = 1'b0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // y = x * clamp(x+3, 0, 6) / 6 in real-valued steps, floor-rounded after +0.5 LSB
    function automatic int ref_lane(input int x, input logic sel);
        int     three = 3 * (1 << FRAC_BITS);
        int     six   = 6 * (1 << FRAC_BITS);
        int     t;
        longint num;
        longint den;
        longint y;
        if (sel) return (x < 0) ? 0 : ((x > six) ? six : x);
        t = x + three;
        if (t < 0) t = 0;
        if (t > six) t = six;
        den = longint'(1) << (16 + FRAC_BITS);
        num = longint'(x * t) * 10923 + den / 2;
        y = num / den;
        if (num < 0 && (num % den) != 0) y = y - 1;
        if (y > (1 << (DATA_W - 1)) - 1) y = (1 << (DATA_W - 1)) - 1;
        if (y < -(1 << (DATA_W - 1))) y = -(1 << (DATA_W - 1));
        return int'(y);
    endfunction

    function automatic logic [W-1:0] ref_beat(input logic [W-1:0] d, input logic sel);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            int x;
            x = int'($signed(d[i*DATA_W +: DATA_W]));
            r[i*DATA_W +: DATA_W] = DATA_W'(ref_lane(x, sel));
        end
        return r;
    endfunction

    // Scoreboard monitor, sampled mid-low-phase so every value is settled.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            sb.delete();
            took       = 1'b0;
            prev_stall = 1'b0;
        end else begin
            cyc++;
            check("in_ready_adv", in_ready, !out_valid || out_ready);
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
                check("hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("spurious_out", out_valid, 0);
                end else begin
                    beat_t b;
                    b = sb.pop_front();
                    check("lane_data", out_data, ref_beat(b.data, b.sel));
                    check("out_last", out_last, b.last);
                    if (full_rate) check("latency", cyc - b.cyc, 3);
                end
            end
            if (in_valid && in_ready) begin
                beat_t nb;
                nb.data = in_data;
                nb.last = in_last;
                nb.sel  = relu6_sel;
                nb.cyc  = cyc;
                sb.push_back(nb);
            end
            took       = in_valid && in_ready;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic directed(input string tag, input logic [W-1:0] beat, input logic sel,
                            input logic [W-1:0] exp);
        int           found;
        logic [W-1:0] got;
        found = 0;
        got   = '0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = beat;
        in_last   = 1'b1;
        relu6_sel = sel;
        out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_last  = 1'b0;
            #3;
            if (found == 0 && out_valid) begin
                found = k;
                got   = out_data;
            end
        end
        check({tag, "_lat"}, found, 3);
        check(tag, got, exp);
    endtask

    task automatic stream(input int n, input int low_pct, input int valid_pct);
        int sent;
        int guard;
        sent  = 0;
        guard = 0;
        while (sent < n && guard < n * 20) begin
            @(negedge clk);
            guard++;
            if (in_valid && took) sent++;
            out_ready = ($urandom_range(99) >= low_pct);
            if (sent >= n) begin
                in_valid = 1'b0;
            end else if (!in_valid || took) begin
                in_valid = ($urandom_range(99) < valid_pct);
                in_data  = W'($urandom);
                in_last  = ($urandom_range(7) == 0);
`ifdef ACT_RELU6_EN
                relu6_sel = ~relu6_sel;
`endif
            end
        end
        in_valid = 1'b0;
        check("stream_sent", sent, n);
    endtask

    task automatic drain();
        int guard;
        guard     = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        #3;
        check("drain_left", sb.size(), 0);
        check("drain_idle", out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        relu6_sel = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        full_rate = 1'b1;
        directed("x_p1_0",   W'(8'd16),  1'b0, W'(8'd11));
        directed("x_p3_0",   W'(8'd48),  1'b0, W'(8'd48));
        directed("x_m1_0",   W'(8'hF0),  1'b0, W'(8'hFB));
        directed("x_m4_0",   W'(8'hC0),  1'b0, W'(8'h00));
        directed("x_max",    W'(8'h7F),  1'b0, W'(8'h7F));
        directed("x_min",    W'(8'h80),  1'b0, W'(8'h00));
`ifdef ACT_RELU6_EN
        directed("relu6",    32'h0070_28F0, 1'b1, 32'h0060_2800);
        directed("relu6_off", 32'h0070_28F0, 1'b0, ref_beat(32'h0070_28F0, 1'b0));
`endif

        stream(64, 0, 100);
        drain();

        full_rate = 1'b0;
        stream(200, 40, 75);
        drain();

        // Reset with three beats in flight, then confirm clean restart latency.
        full_rate = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = W'($urandom);
            in_last   = 1'b1;
            out_ready = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_last", out_last, 0);
        check("midrst_data", out_data, 0);
        @(negedge clk);
        check("midrst_hold", out_valid, 0);
        rst_n = 1'b1;
        stream(4, 0, 100);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
